// File: rtl/iter_logic_shift_unit.sv
// Iterative logic/shift unit: single-cycle logic ops,
// shifts performed one bit per cycle through the result register.
module iter_logic_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [SHW-1:0] amt;
  logic           is_shift;

  assign amt      = B[SHW-1:0];
  assign is_shift = op[2] & ~(op[1] & op[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (is_shift && amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == SHW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // res_q doubles as the shift accumulator
  always_comb begin
    op_d  = op_q;
    cnt_d = cnt_q;
    res_d = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op;
          cnt_d = amt;
          unique case (op)
            3'b000:  res_d = A & B;
            3'b001:  res_d = A | B;
            3'b010:  res_d = A ^ B;
            3'b011:  res_d = ~(A | B);
            3'b111:  res_d = B;
            default: res_d = A;
          endcase
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - SHW'(1);
        unique case (op_q)
          3'b100:  res_d = {res_q[WIDTH-2:0], 1'b0};
          3'b101:  res_d = {1'b0, res_q[WIDTH-1:1]};
          default: res_d = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      op_q  <= op_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

  assign res  = res_q;
  assign zero = ~|res_q;

endmodule

// File: doc/iter_logic_shift_unit.md
ITER_LOGIC_SHIFT_UNIT -- requirements
Module: iter_logic_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=2).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLL, 101 SRL, 110 SRA, 111 pass B.
REQ-008 SHALL have port A  input  WIDTH  first operand; the value shifted for shift ops.
REQ-009 SHALL have port B  input  WIDTH  second operand; B[SHW-1:0] is the shift amount for shift ops.
REQ-010 SHALL have port out_valid  output  1  res holds a completed result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port res  output  WIDTH  result.
REQ-013 SHALL have port zero  output  1  res == 0, valid whenever out_valid=1.

Function
REQ-014 SHALL implement states IDLE, SHIFT, DONE; in_ready=1 only in IDLE (combinational from state).
REQ-015 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, capturing op, A and B[SHW-1:0]; in_valid is ignored outside IDLE.
REQ-016 For ops 000-011 and 111, SHALL compute the result in the accept cycle, load it into res and go to DONE (out_valid=1 exactly 1 cycle after accept).
REQ-017 For shift ops with amount 0, SHALL load res=A and go to DONE (1-cycle latency).
REQ-018 For shift ops with amount n>0, SHALL load an accumulator with A and a counter with n, then enter SHIFT.
REQ-019 In SHIFT, each cycle SHALL shift the accumulator by exactly 1 bit (SLL: zero into LSB; SRL: zero into MSB; SRA: replicate MSB) and decrement the counter.
REQ-020 SHALL leave SHIFT for DONE on the edge that performs the n-th shift; out_valid=1 exactly n+1 cycles after accept.
REQ-021 SHALL keep res at 0 until the first load; the accumulator is res, so res is undefined-for-use (but deterministic) while out_valid=0.
REQ-022 In DONE, SHALL hold res, zero and out_valid=1 stable until out_ready=1.
REQ-023 On an edge in DONE with out_ready=1, SHALL clear out_valid and return to IDLE; a new request is accepted at the earliest on the following edge (no same-cycle turnaround).
REQ-024 out_ready SHALL be ignored outside DONE; in_valid during SHIFT/DONE SHALL neither be captured nor alter the in-flight operation.
REQ-025 Shift amounts SHALL use only B[SHW-1:0]; for WIDTH not a power of two, amounts >= WIDTH SHALL still iterate n times (result 0 for SLL/SRL, all-sign for SRA).
REQ-026 zero SHALL be derived from res combinationally and be 1 after reset.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, res=0, counter=0, out_valid=0; in_ready=1 while in reset.
REQ-028 Reset asserted during SHIFT or DONE SHALL abort the operation; no out_valid for it ever appears after rst_n deasserts.
REQ-029 First acceptance after reset SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-030 XOR: op=010, A=32'hffffff00, B=32'h00000f01 -> out_valid 1 cycle after accept, res=32'hfffff001, zero=0.
REQ-031 SRL: op=101, A=32'hffffff00, B=32'h00000f01 (n=1) -> out_valid 2 cycles after accept, res=32'h7fffff80; SRA op=110, A=32'h80000000, B=4 -> 5 cycles, res=32'hf8000000.
REQ-032 SLL zero/boundary: op=100, A=32'h12345678, B=0 -> 1 cycle, res=32'h12345678; B=31, A=1 -> 32 cycles, res=32'h80000000; NOR A=B=32'hffffffff -> res=0, zero=1.
REQ-033 Backpressure: complete AND with out_ready=0 for 5 cycles -> res/out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-034 Reset mid-op: SRL by 20 accepted, rst_n=0 at cycle 7 -> out_valid=0, res=0, in_ready=1 immediately; after release, OR A=32'hf0, B=32'h0f -> res=32'hff after 1 cycle.
REQ-035 Back-to-back: three requests with out_ready=1 and in_valid held -> each accepted in IDLE only, results in order, one idle cycle between DONE and next accept.
